acs_radix2_param: RTL and testbench

//   Parametrised add-compare-select unit for the hard-decision Viterbi decoder; replaces the fixed 4-state ACS.

---
 rtl/acs_radix2_param_if.sv | 30 +++
 rtl/acs_radix2_param.sv | 134 +++++++++++++
 tb/tb_acs_radix2_param.sv | 291 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/acs_radix2_param_if.sv
// Symbol/metric bus between the branch metric unit, the ACS and the traceback memory.
// The master drives branch metrics in; the slave (ACS) returns decisions and the best state.
interface acs_radix2_param_if #(
  parameter int unsigned K     = 3,
  parameter int unsigned BM_W  = 4,
  parameter int unsigned PM_W  = 8,
  parameter int unsigned CNT_W = 8
);
  localparam int unsigned NumSt = 1 << (K - 1);

  logic                i_start;
  logic                i_valid;
  logic [4*BM_W-1:0]   i_bm;
  logic                o_valid;
  logic [NumSt-1:0]    o_dec;
  logic [K-2:0]        o_best_st;
  logic [PM_W-1:0]     o_best_pm;
  logic                o_norm;
  logic [CNT_W-1:0]    o_sym_cnt;

  modport master (
    output i_start, i_valid, i_bm,
    input  o_valid, o_dec, o_best_st, o_best_pm, o_norm, o_sym_cnt
  );

  modport slave (
    input  i_start, i_valid, i_bm,
    output o_valid, o_dec, o_best_st, o_best_pm, o_norm, o_sym_cnt
  );
endinterface

// File: rtl/acs_radix2_param.sv
// Radix-2 add-compare-select for a hard-decision Viterbi decoder with 2^(K-1) states.
// One symbol per cycle, saturating metrics, modulo normalisation and frame start/re-init.
module acs_radix2_param #(
  parameter int unsigned K     = 3,
  parameter int unsigned G0    = 'o7,
  parameter int unsigned G1    = 'o5,
  parameter int unsigned BM_W  = 4,
  parameter int unsigned PM_W  = 8,
  parameter int unsigned CNT_W = 8
) (
  input logic               clk,
  input logic               rst,
  acs_radix2_param_if.slave bus
);
  localparam int unsigned      NumSt  = 1 << (K - 1);
  localparam logic [PM_W-1:0]  PmMax  = '1;
  localparam logic [PM_W-1:0]  PmHalf = {1'b1, {(PM_W - 1){1'b0}}};
  localparam logic [PM_W-1:0]  PmInit = {2'b01, {(PM_W - 2){1'b0}}};
  localparam logic [CNT_W-1:0] CntMax = '1;

  logic [NumSt-1:0][PM_W-1:0] pm_q, pm_d, pm_init, pm_prev, pm_acs, pm_norm;
  logic [NumSt-1:0]           dec_q, dec_d, dec_acs;
  logic [K-2:0]               best_st_q, best_st_d, best_st_c;
  logic [PM_W-1:0]            best_pm_q, best_pm_d, best_pm_c;
  logic                       valid_q, valid_d;
  logic                       norm_q, norm_d, norm_c;
  logic [CNT_W-1:0]           cnt_q, cnt_d;

  always_comb begin
    pm_init = '0;
    for (int s = 1; s < NumSt; s++) begin
      pm_init[s] = PmInit;
    end
  end

  // ACS over all next states; the branch register {u,p_b} is simply {ns,b}.
  always_comb begin
    logic [K-1:0]          br;
    logic [1:0]            cw;
    logic [PM_W:0]         sum;
    logic [1:0][PM_W-1:0]  cand;
    logic [PM_W-1:0]       min_pm;
    br      = '0;
    cw      = '0;
    sum     = '0;
    cand    = '0;
    pm_acs  = '0;
    dec_acs = '0;
    pm_prev = bus.i_start ? pm_init : pm_q;
    for (int ns = 0; ns < NumSt; ns++) begin
      for (int b = 0; b < 2; b++) begin
        br      = K'((ns << 1) | b);
        cw      = {^(br & K'(G0)), ^(br & K'(G1))};
        sum     = {1'b0, pm_prev[br[K-2:0]]}
                + {{(PM_W + 1 - BM_W){1'b0}}, bus.i_bm[int'(cw)*BM_W +: BM_W]};
        cand[b] = sum[PM_W] ? PmMax : sum[PM_W-1:0];
      end
      dec_acs[ns] = cand[1] < cand[0];
      pm_acs[ns]  = dec_acs[ns] ? cand[1] : cand[0];
    end

    min_pm = pm_acs[0];
    for (int s = 1; s < NumSt; s++) begin
      if (pm_acs[s] < min_pm) min_pm = pm_acs[s];
    end
    norm_c = min_pm >= PmHalf;
    // Saturated metrics are left pinned so a dead path never looks good again.
    for (int s = 0; s < NumSt; s++) begin
      pm_norm[s] = (norm_c && pm_acs[s] != PmMax) ? pm_acs[s] - PmHalf : pm_acs[s];
    end

    best_pm_c = pm_norm[0];
    best_st_c = '0;
    for (int s = 1; s < NumSt; s++) begin
      if (pm_norm[s] < best_pm_c) begin
        best_pm_c = pm_norm[s];
        best_st_c = s[K-2:0];
      end
    end
  end

  always_comb begin
    pm_d      = pm_q;
    dec_d     = dec_q;
    best_st_d = best_st_q;
    best_pm_d = best_pm_q;
    cnt_d     = cnt_q;
    valid_d   = 1'b0;
    norm_d    = 1'b0;
    if (bus.i_valid) begin
      pm_d      = pm_norm;
      dec_d     = dec_acs;
      best_st_d = best_st_c;
      best_pm_d = best_pm_c;
      norm_d    = norm_c;
      valid_d   = 1'b1;
      if (bus.i_start) begin
        cnt_d = CNT_W'(1);
      end else if (cnt_q != CntMax) begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (bus.i_start) begin
      pm_d  = pm_init;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm_q      <= pm_init;
      dec_q     <= '0;
      best_st_q <= '0;
      best_pm_q <= '0;
      valid_q   <= 1'b0;
      norm_q    <= 1'b0;
      cnt_q     <= '0;
    end else begin
      pm_q      <= pm_d;
      dec_q     <= dec_d;
      best_st_q <= best_st_d;
      best_pm_q <= best_pm_d;
      valid_q   <= valid_d;
      norm_q    <= norm_d;
      cnt_q     <= cnt_d;
    end
  end

  assign bus.o_valid   = valid_q;
  assign bus.o_dec     = dec_q;
  assign bus.o_best_st = best_st_q;
  assign bus.o_best_pm = best_pm_q;
  assign bus.o_norm    = norm_q;
  assign bus.o_sym_cnt = cnt_q;
endmodule

// File: tb/tb_acs_radix2_param.sv
// Bench for acs_radix2_param (K=3, G0=7, G1=5): directed trellis cases plus random symbols
// checked against a forward-trellis metric model.
module tb_acs_radix2_param;
  localparam int K     = 3;
  localparam int NST   = 4;
  localparam int BM_W  = 4;
  localparam int PM_W  = 8;
  localparam int CNT_W = 8;
  localparam int G0    = 'o7;
  localparam int G1    = 'o5;
  localparam int PMAX  = 255;
  localparam int HALF  = 128;
  localparam int INIT  = 64;
  localparam logic [15:0] BM_T1 = 16'h2110;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  acs_radix2_param_if #(.K(K), .BM_W(BM_W), .PM_W(PM_W), .CNT_W(CNT_W)) bus ();

  acs_radix2_param #(
    .K(K), .G0(G0), .G1(G1), .BM_W(BM_W), .PM_W(PM_W), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int             total = 0;
  int             bad = 0;
  int             m_pm[NST];
  logic [NST-1:0] m_dec;
  int             m_best_st, m_best_pm, m_cnt;
  bit             m_valid, m_norm;

  function automatic int par(input int v);
    return $countones(v) & 1;
  endfunction

  task automatic mdl_reset();
    for (int s = 0; s < NST; s++) m_pm[s] = (s == 0) ? 0 : INIT;
    m_dec = '0; m_best_st = 0; m_best_pm = 0; m_cnt = 0; m_valid = 0; m_norm = 0;
  endtask

  // Forward view: every state s emits two branches (input u) into ns; the branch
  // is tagged with the LSB of s, which is the bit a traceback would recover.
  task automatic mdl_step(input bit start, input bit valid, input logic [15:0] bm);
    int cand[NST][2];
    int nw[NST];
    int mn;
    if (start) begin
      for (int s = 0; s < NST; s++) m_pm[s] = (s == 0) ? 0 : INIT;
      if (!valid) m_cnt = 0;
    end
    if (!valid) begin
      m_valid = 0; m_norm = 0;
      return;
    end
    for (int s = 0; s < NST; s++) begin
      for (int u = 0; u < 2; u++) begin
        int rv, ns, cwi, m;
        rv  = (u << (K - 1)) | s;
        cwi = par(rv & G0) * 2 + par(rv & G1);
        ns  = (u << (K - 2)) | (s >> 1);
        m   = m_pm[s] + int'(bm[cwi*BM_W +: BM_W]);
        if (m > PMAX) m = PMAX;
        cand[ns][s % 2] = m;
      end
    end
    mn = PMAX + 1;
    for (int ns = 0; ns < NST; ns++) begin
      m_dec[ns] = cand[ns][1] < cand[ns][0];
      nw[ns] = m_dec[ns] ? cand[ns][1] : cand[ns][0];
      if (nw[ns] < mn) mn = nw[ns];
    end
    m_norm = (mn >= HALF);
    for (int ns = 0; ns < NST; ns++) begin
      if (m_norm && nw[ns] != PMAX) nw[ns] -= HALF;
      m_pm[ns] = nw[ns];
    end
    m_best_st = 0; m_best_pm = m_pm[0];
    for (int s = 1; s < NST; s++) if (m_pm[s] < m_best_pm) begin
      m_best_pm = m_pm[s]; m_best_st = s;
    end
    m_valid = 1;
    m_cnt = start ? 1 : ((m_cnt < 255) ? m_cnt + 1 : 255);
  endtask

  task automatic drive(input bit start, input bit valid, input logic [15:0] bm);
    bus.i_start = start; bus.i_valid = valid; bus.i_bm = bm;
    @(posedge clk); #1;
    mdl_step(start, valid, bm);
    bus.i_start = 1'b0; bus.i_valid = 1'b0;
  endtask

  task automatic do_reset();
    bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_bm = '0;
    rst = 1'b0;
    #3;
    mdl_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    do_reset();
    total += 6;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.o_valid); end
    if (bus.o_dec !== 4'b0) begin bad++; $display("FAIL rst_dec got=%b want=0", bus.o_dec); end
    if (bus.o_best_st !== 2'd0) begin bad++; $display("FAIL rst_best_st got=%0d want=0", bus.o_best_st); end
    if (bus.o_best_pm !== 8'd0) begin bad++; $display("FAIL rst_best_pm got=%0d want=0", bus.o_best_pm); end
    if (bus.o_norm !== 1'b0) begin bad++; $display("FAIL rst_norm got=%b want=0", bus.o_norm); end
    if (bus.o_sym_cnt !== 8'd0) begin bad++; $display("FAIL rst_cnt got=%0d want=0", bus.o_sym_cnt); end
  endtask

  task automatic test_first_symbol();
    do_reset();
    drive(1'b0, 1'b1, BM_T1);
    total += 6;
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL t1_valid got=%b want=1", bus.o_valid); end
    if (bus.o_dec !== 4'b0000) begin bad++; $display("FAIL t1_dec got=%b want=0000", bus.o_dec); end
    if (bus.o_best_st !== 2'd0) begin bad++; $display("FAIL t1_best_st got=%0d want=0", bus.o_best_st); end
    if (bus.o_best_pm !== 8'd0) begin bad++; $display("FAIL t1_best_pm got=%0d want=0", bus.o_best_pm); end
    if (dut.pm_q[2] !== 8'd2) begin bad++; $display("FAIL t1_pm2 got=%0d want=2", dut.pm_q[2]); end
    if (bus.o_sym_cnt !== 8'd1) begin bad++; $display("FAIL t1_cnt got=%0d want=1", bus.o_sym_cnt); end
    drive(1'b0, 1'b0, 16'hffff);
    total += 2;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL idle_valid got=%b want=0", bus.o_valid); end
    if (bus.o_sym_cnt !== 8'd1) begin bad++; $display("FAIL idle_cnt got=%0d want=1", bus.o_sym_cnt); end
  endtask

  task automatic test_normalise();
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      drive(1'b0, 1'b1, 16'hffff);
      if (i == 8) begin
        total += 2;
        if (bus.o_best_pm !== 8'd120) begin bad++; $display("FAIL norm8_pm got=%0d want=120", bus.o_best_pm); end
        if (bus.o_norm !== 1'b0) begin bad++; $display("FAIL norm8_flag got=%b want=0", bus.o_norm); end
      end
    end
    total += 2;
    if (bus.o_best_pm !== 8'd7) begin bad++; $display("FAIL norm9_pm got=%0d want=7", bus.o_best_pm); end
    if (bus.o_norm !== 1'b1) begin bad++; $display("FAIL norm9_flag got=%b want=1", bus.o_norm); end
  endtask

  task automatic test_tie();
    do_reset();
    drive(1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b1, 16'h0000);
    drive(1'b0, 1'b1, 16'h0000);
    total += 4;
    if (bus.o_dec[0] !== 1'b0) begin bad++; $display("FAIL tie_dec0 got=%b want=0", bus.o_dec[0]); end
    if (bus.o_dec[2] !== 1'b0) begin bad++; $display("FAIL tie_dec2 got=%b want=0", bus.o_dec[2]); end
    if (bus.o_best_st !== 2'd0) begin bad++; $display("FAIL tie_best_st got=%0d want=0", bus.o_best_st); end
    if (bus.o_best_pm !== 8'd0) begin bad++; $display("FAIL tie_best_pm got=%0d want=0", bus.o_best_pm); end
  endtask

  task automatic test_encode();
    int             bits[6] = '{1, 0, 1, 1, 0, 0};
    logic [NST-1:0] decs[6];
    logic [15:0]    bm;
    int             st, rv, code, got;
    st = 0;
    for (int t = 0; t < 6; t++) begin
      rv   = (bits[t] << (K - 1)) | st;
      code = par(rv & G0) * 2 + par(rv & G1);
      for (int cw = 0; cw < 4; cw++) bm[cw*BM_W +: BM_W] = 4'($countones(cw ^ code));
      st = (bits[t] << (K - 2)) | (st >> 1);
      drive(t == 0, 1'b1, bm);
      decs[t] = bus.o_dec;
      total++;
      if (bus.o_best_pm !== 8'd0) begin
        bad++; $display("FAIL enc_pm%0d got=%0d want=0", t, bus.o_best_pm);
      end
    end
    total++;
    if (bus.o_best_st !== 2'd0) begin bad++; $display("FAIL enc_end_st got=%0d want=0", bus.o_best_st); end
    st = int'(bus.o_best_st);
    for (int t = 5; t >= 0; t--) begin
      got = st >> (K - 2);
      st  = ((st << 1) & (NST - 1)) | int'(decs[t][st]);
      total++;
      if (got != bits[t]) begin bad++; $display("FAIL enc_tb_bit%0d got=%0d want=%0d", t, got, bits[t]); end
    end
  endtask

  task automatic test_start();
    logic [15:0] bm;
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 16'($urandom));
    bm = 16'($urandom);
    drive(1'b1, 1'b1, bm);
    total += 4;
    if (bus.o_sym_cnt !== 8'd1) begin bad++; $display("FAIL st_cnt got=%0d want=1", bus.o_sym_cnt); end
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL st_valid got=%b want=1", bus.o_valid); end
    if (bus.o_dec !== m_dec) begin bad++; $display("FAIL st_dec got=%b want=%b", bus.o_dec, m_dec); end
    if (bus.o_best_pm !== 8'(m_best_pm)) begin
      bad++; $display("FAIL st_pm got=%0d want=%0d", bus.o_best_pm, m_best_pm);
    end
    drive(1'b1, 1'b0, 16'($urandom));
    total += 2;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL st_only_valid got=%b want=0", bus.o_valid); end
    if (bus.o_sym_cnt !== 8'd0) begin bad++; $display("FAIL st_only_cnt got=%0d want=0", bus.o_sym_cnt); end
    drive(1'b0, 1'b1, BM_T1);
    total += 2;
    if (bus.o_best_pm !== 8'd0) begin bad++; $display("FAIL st_t1_pm got=%0d want=0", bus.o_best_pm); end
    if (bus.o_sym_cnt !== 8'd1) begin bad++; $display("FAIL st_t1_cnt got=%0d want=1", bus.o_sym_cnt); end
  endtask

  task automatic test_random();
    bit          st, vl;
    logic [15:0] bm;
    for (int i = 0; i < 300; i++) begin
      vl = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 19) == 0);
      bm = 16'($urandom);
      if ($urandom_range(0, 3) == 0) bm = 16'hffff;
      drive(st, vl, bm);
      total += 6;
      if (bus.o_valid !== m_valid) begin
        bad++; $display("FAIL rnd%0d_valid got=%b want=%b", i, bus.o_valid, m_valid);
      end
      if (bus.o_dec !== m_dec) begin
        bad++; $display("FAIL rnd%0d_dec got=%b want=%b", i, bus.o_dec, m_dec);
      end
      if (bus.o_best_st !== 2'(m_best_st)) begin
        bad++; $display("FAIL rnd%0d_best_st got=%0d want=%0d", i, bus.o_best_st, m_best_st);
      end
      if (bus.o_best_pm !== 8'(m_best_pm)) begin
        bad++; $display("FAIL rnd%0d_best_pm got=%0d want=%0d", i, bus.o_best_pm, m_best_pm);
      end
      if (bus.o_norm !== m_norm) begin
        bad++; $display("FAIL rnd%0d_norm got=%b want=%b", i, bus.o_norm, m_norm);
      end
      if (bus.o_sym_cnt !== 8'(m_cnt)) begin
        bad++; $display("FAIL rnd%0d_cnt got=%0d want=%0d", i, bus.o_sym_cnt, m_cnt);
      end
    end
  endtask

  task automatic test_rst_burst();
    do_reset();
    drive(1'b0, 1'b1, 16'($urandom));
    drive(1'b0, 1'b1, 16'($urandom));
    bus.i_valid = 1'b1; bus.i_bm = 16'($urandom);
    #2 rst = 1'b0;
    #1;
    total += 2;
    if (bus.o_valid !== 1'b0) begin bad++; $display("FAIL rstb_valid got=%b want=0", bus.o_valid); end
    if (bus.o_sym_cnt !== 8'd0) begin bad++; $display("FAIL rstb_cnt got=%0d want=0", bus.o_sym_cnt); end
    bus.i_valid = 1'b0;
    mdl_reset();
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    drive(1'b0, 1'b1, BM_T1);
    total += 4;
    if (bus.o_valid !== 1'b1) begin bad++; $display("FAIL rstb_t1_valid got=%b want=1", bus.o_valid); end
    if (bus.o_dec !== 4'b0000) begin bad++; $display("FAIL rstb_t1_dec got=%b want=0000", bus.o_dec); end
    if (bus.o_best_pm !== 8'd0) begin bad++; $display("FAIL rstb_t1_pm got=%0d want=0", bus.o_best_pm); end
    if (bus.o_sym_cnt !== 8'd1) begin bad++; $display("FAIL rstb_t1_cnt got=%0d want=1", bus.o_sym_cnt); end
  endtask

  task automatic test_cnt_sat();
    do_reset();
    for (int i = 0; i < 254; i++) drive(1'b0, 1'b1, 16'($urandom));
    total++;
    if (bus.o_sym_cnt !== 8'd254) begin bad++; $display("FAIL cnt254 got=%0d want=254", bus.o_sym_cnt); end
    drive(1'b0, 1'b1, 16'($urandom));
    total++;
    if (bus.o_sym_cnt !== 8'd255) begin bad++; $display("FAIL cnt255 got=%0d want=255", bus.o_sym_cnt); end
    for (int i = 0; i < 5; i++) drive(1'b0, 1'b1, 16'($urandom));
    total++;
    if (bus.o_sym_cnt !== 8'd255) begin bad++; $display("FAIL cnt_hold got=%0d want=255", bus.o_sym_cnt); end
  endtask

  initial begin
    bus.i_start = 1'b0; bus.i_valid = 1'b0; bus.i_bm = '0;
    test_reset();
    test_first_symbol();
    test_normalise();
    test_tie();
    test_encode();
    test_start();
    test_random();
    test_rst_burst();
    test_cnt_sat();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
